// File: rtl/router_1xn.sv
// router_1xn: byte-serial 1-to-N packet router with one FIFO per channel.
// Header byte holds the channel address (low bits) and the payload length (high bits).
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   pkt_valid, data_in  packet byte stream from the source
//   read_enb            per-channel pop request
//   data_out            registered channel heads, channel i at [i*DATA_W +: DATA_W]
//   vld_out             per-channel FIFO non-empty flag
//   soft_reset          per-channel one-cycle flush pulse
//   busy                input byte held back this cycle
//   err                 last packet had bad parity, length or address
// Option: defining ROUTER_SOFT_RESET_EN enables the per-channel idle-read timeout flush.
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int N_PORTS    = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pkt_valid,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [N_PORTS-1:0]          read_enb,
  output logic [N_PORTS*DATA_W-1:0]   data_out,
  output logic [N_PORTS-1:0]          vld_out,
  output logic [N_PORTS-1:0]          soft_reset,
  output logic                        busy,
  output logic                        err
);

  localparam int ADDR_W = (N_PORTS > 2) ? $clog2(N_PORTS) : 1;
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int SLOTS  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NP = (ADDR_W+1)'(N_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DROP
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] hdr_addr;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_bad;
  logic [ADDR_W-1:0] tgt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    cnt;
  logic [DATA_W-1:0] par;

  // Flag vectors are padded to a power of two so the
  // address can index them directly; pad slots are inert.
  logic [SLOTS-1:0]  empty;
  logic [SLOTS-1:0]  full;
  logic [SLOTS-1:0]  flush;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_sel;
  logic              take_hdr;
  logic              take_byte;
  logic              take_par;
  logic              drop_par;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign hdr_bad  = {1'b0, hdr_addr} >= NP;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = tgt;
    take_hdr  = 1'b0;
    take_byte = 1'b0;
    take_par  = 1'b0;
    drop_par  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pkt_valid) begin
          if (hdr_bad) begin
            state_n = DROP;
          end else if (!empty[hdr_addr]) begin
            // Never start a packet behind another one.
            busy = 1'b1;
          end else begin
            take_hdr = 1'b1;
            wr_en    = 1'b1;
            wr_sel   = hdr_addr;
            state_n  = LOAD;
          end
        end
      end
      LOAD: begin
        busy = full[tgt];
        if (!full[tgt]) begin
          wr_en = 1'b1;
          if (pkt_valid) begin
            take_byte = 1'b1;
          end else begin
            take_par = 1'b1;
            state_n  = IDLE;
          end
        end
        // Target flushed mid-packet: rest of it is garbage.
        if (flush[tgt]) begin
          if (take_par) begin
            take_par = 1'b0;
            drop_par = 1'b1;
          end else begin
            state_n = DROP;
          end
        end
      end
      DROP: begin
        if (!pkt_valid) begin
          drop_par = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tgt   <= '0;
      len_q <= '0;
      cnt   <= '0;
      par   <= '0;
      err   <= 1'b0;
    end else begin
      if (take_hdr) begin
        tgt   <= hdr_addr;
        len_q <= hdr_len;
        cnt   <= '0;
        par   <= data_in;
        err   <= 1'b0;
      end
      if (take_byte) begin
        par <= par ^ data_in;
        // Saturate so an overlong packet cannot wrap to a match.
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
      if (take_par) begin
        err <= (par != data_in) || (cnt != {1'b0, len_q});
      end
      if (drop_par) err <= 1'b1;
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_ch
    if (i < N_PORTS) begin : g_real
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wp;
      logic [PTR_W-1:0]  rp;
      logic [DATA_W-1:0] dq;
      logic              wr;
      logic              rd;

      assign empty[i] = (wp == rp);
      assign full[i]  = (wp[AW] != rp[AW]) &&
                        (wp[AW-1:0] == rp[AW-1:0]);
      assign wr = wr_en && (wr_sel == ADDR_W'(i)) && !flush[i];
      assign rd = read_enb[i] && !empty[i] && !flush[i];

      always_ff @(posedge clock) begin
        if (wr) mem[wp[AW-1:0]] <= data_in;
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          wp <= '0;
          rp <= '0;
          dq <= '0;
        end else if (flush[i]) begin
          wp <= '0;
          rp <= '0;
        end else begin
          if (wr) wp <= wp + 1'b1;
          if (rd) begin
            dq <= mem[rp[AW-1:0]];
            rp <= rp + 1'b1;
          end
        end
      end

      assign data_out[i*DATA_W +: DATA_W] = dq;
      assign vld_out[i] = !empty[i];

`ifdef ROUTER_SOFT_RESET_EN
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] tc;
      logic          sr;

      // sr is raised in the cycle the idle count reaches
      // TIMEOUT; the flush takes effect on the following edge.
      always_ff @(posedge clock) begin
        if (reset) begin
          tc <= '0;
          sr <= 1'b0;
        end else if (sr) begin
          tc <= '0;
          sr <= 1'b0;
        end else if (vld_out[i] && !read_enb[i]) begin
          tc <= tc + 1'b1;
          sr <= (tc == TW'(TIMEOUT - 1));
        end else begin
          tc <= '0;
        end
      end

      assign soft_reset[i] = sr;
      assign flush[i]      = sr;
`else
      assign soft_reset[i] = 1'b0;
      assign flush[i]      = 1'b0;
`endif
    end else begin : g_pad
      assign empty[i] = 1'b1;
      assign full[i]  = 1'b0;
      assign flush[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: scoreboard bench for router_1xn.
// Expected bytes are queued per channel at issue; a monitor checks each read.
module tb_router_1xn;

  localparam int DW = 8;
  localparam int NP = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic [NP-1:0] read_enb;
  logic [NP*DW-1:0] data_out;
  logic [NP-1:0] vld_out;
  logic [NP-1:0] soft_reset;
  logic          busy;
  logic          err;

  router_1xn #(
    .DATA_W    (DW),
    .N_PORTS   (NP),
    .FIFO_DEPTH(4),
    .TIMEOUT   (30)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .vld_out   (vld_out),
    .soft_reset(soft_reset),
    .busy      (busy),
    .err       (err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int sent_cnt = 0;
  int v2_cnt = 0;
  bit busy_seen = 0;
  bit sr_seen = 0;

  logic [DW-1:0] exp_q [NP][$];
  logic [DW-1:0] pkt [$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each effective read must produce the next queued byte.
  always @(posedge clock) begin
    logic [NP-1:0] rd;
    rd = read_enb & vld_out & {NP{!reset}};
    #1;
    for (int i = 0; i < NP; i++) begin
      if (rd[i]) begin
        if (exp_q[i].size() == 0)
          check($sformatf("unexp_read_ch%0d", i), 1, 0);
        else
          check($sformatf("data_ch%0d", i),
                int'(data_out[i*DW +: DW]), int'(exp_q[i].pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    #2;
    if (busy) busy_seen = 1;
    if (soft_reset != '0) sr_seen = 1;
  end

  always @(negedge clock) begin
    #1;
    if (vld_out[2] && !soft_reset[2] && !read_enb[2]) v2_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send_byte(input logic pv, input logic [DW-1:0] d);
    int t;
    t = 0;
    pkt_valid = pv;
    data_in   = d;
    #1;
    while (busy && t < 100) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (busy) check("send_stall", 1, 0);
    else begin
      @(posedge clock);
      sent_cnt++;
    end
    @(negedge clock);
  endtask

  task automatic send_pkt(input int ch, input bit store);
    sent_cnt = 0;
    for (int k = 0; k < pkt.size(); k++) begin
      if (store) exp_q[ch].push_back(pkt[k]);
      send_byte(k != pkt.size() - 1, pkt[k]);
    end
    pkt_valid = 1'b0;
    data_in   = '0;
  endtask

  task automatic drain(input int ch);
    int t;
    t = 0;
    while (exp_q[ch].size() != 0 && t < 60) begin
      @(negedge clock);
      t++;
    end
    check($sformatf("drain_ch%0d", ch), exp_q[ch].size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    pkt_valid = 1'b0;
    data_in = '0;
    read_enb = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_data_out", int'(data_out), 0);
    check("rst_vld_out", int'(vld_out), 0);
    check("rst_soft_reset", int'(soft_reset), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    @(negedge clock);

    // Good packet to channel 1, read while loading.
    read_enb = 3'b010;
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    send_pkt(1, 1);
    check("t1_err", int'(err), 0);
    drain(1);
    check("t1_vld_other", int'({vld_out[2], vld_out[0]}), 0);

    // Same packet, wrong parity: stored, err set.
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    send_pkt(1, 1);
    check("t2_err", int'(err), 1);
    drain(1);

    // Illegal address 3: dropped without stalling.
    read_enb = 3'b000;
    busy_seen = 0;
    pkt = '{8'h07, 8'hAA, 8'hAD};
    send_pkt(0, 0);
    check("t3_busy_seen", int'(busy_seen), 0);
    check("t3_consumed", sent_cnt, 3);
    check("t3_vld", int'(vld_out), 0);
    check("t3_err", int'(err), 1);

    // len 8 to channel 0 with no reads: stalls once full.
    pkt = '{8'h20, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'h28};
    fork
      send_pkt(0, 1);
      begin
        int t;
        t = 0;
        do begin
          @(negedge clock);
          #2;
          t++;
        end while (!busy && t < 30);
        check("t4_busy", int'(busy), 1);
        check("t4_fill", sent_cnt, 4);
        repeat (3) begin
          @(negedge clock);
          #2;
        end
        check("t4_still_busy", int'(busy), 1);
        check("t4_no_more", sent_cnt, 4);
        read_enb[0] = 1'b1;
      end
    join
    check("t4_err", int'(err), 0);
    drain(0);
    read_enb = 3'b000;
    @(negedge clock);

    // Unread packet on channel 2.
    pkt = '{8'h02, 8'h02};
    v2_cnt = 0;
    sr_seen = 0;
`ifdef ROUTER_SOFT_RESET_EN
    send_pkt(2, 0);
    begin
      int t;
      t = 0;
      #1;
      while (!soft_reset[2] && t < 60) begin
        @(negedge clock);
        #1;
        t++;
      end
    end
    check("t5_pulse", int'(soft_reset[2]), 1);
    check("t5_idle_cycles", v2_cnt, 30);
    @(negedge clock);
    #1;
    check("t5_width", int'(soft_reset[2]), 0);
    check("t5_flushed", int'(vld_out[2]), 0);
`else
    send_pkt(2, 1);
    repeat (40) @(negedge clock);
    check("t5_no_pulse", int'(sr_seen), 0);
    check("t5_held", int'(vld_out[2]), 1);
    check("t5_idle_cycles", v2_cnt, 41);
    read_enb = 3'b100;
    drain(2);
    read_enb = 3'b000;
`endif
    @(negedge clock);

    // Second packet behind a stored one on channel 0.
    pkt = '{8'h04, 8'h77, 8'h73};
    send_pkt(0, 1);
    pkt = '{8'h08, 8'hA1, 8'hB2, 8'h1B};
    fork
      send_pkt(0, 1);
      begin
        repeat (6) begin
          @(negedge clock);
          #2;
        end
        check("t6_busy", int'(busy), 1);
        check("t6_hold", sent_cnt, 0);
        check("t6_vld", int'(vld_out[0]), 1);
        read_enb[0] = 1'b1;
      end
    join
    check("t6_err", int'(err), 0);
    drain(0);
    read_enb = 3'b000;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
